// File: rtl/float_addsub_pipelined_param.sv
// float_addsub_pipelined_param: 4-stage parametrised FP add/sub, RNE, valid/ready.
// Define FLOAT_ADDSUB_FTZ_EN to flush subnormal inputs and results to zero.
module float_addsub_pipelined_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   num1,
  input  logic [EXP_W+MAN_W:0]   num2,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   zero,
  output logic                   NaN,
  output logic                   precisionLost
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 1;
  localparam int GW     = MAN_W + 4;
  localparam int SW     = MAN_W + 5;
  localparam int TW     = MW + GW - 1;
  localparam int AW     = $clog2(MAN_W + 4);
  localparam int LW     = $clog2(GW + 1);
  localparam int EMAX_I = (2 ** EXP_W) - 1;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [MAN_W-1:0] MZ   = '0;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MW-1:0]    m;
    logic             nan;
    logic             inf;
  } unp_t;

  typedef struct packed {
    logic             vld;
    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MW-1:0]    ma;
    logic [MW-1:0]    mb;
    logic             nan;
    logic             inf;
    logic             inf_s;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             sa;
    logic             sub;
    logic             zs;
    logic [EXP_W-1:0] ea;
    logic [GW-1:0]    a;
    logic [GW-1:0]    b;
    logic             nan;
    logic             inf;
    logic             inf_s;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic             sa;
    logic             zs;
    logic [EXP_W-1:0] ea;
    logic [SW-1:0]    sum;
    logic [LW-1:0]    lz;
    logic             nan;
    logic             inf;
    logic             inf_s;
  } s3_t;

  function automatic unp_t unpack(
    input logic [W-1:0] x,
    input logic         flip
  );
    unp_t             u;
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] fr;
    ex    = x[W-2:MAN_W];
    fr    = x[MAN_W-1:0];
    u.s   = x[W-1] ^ flip;
    u.nan = (ex == EMAX) && (fr != '0);
    u.inf = (ex == EMAX) && (fr == '0);
`ifdef FLOAT_ADDSUB_FTZ_EN
    if (ex == '0) fr = '0;
`endif
    u.e = (ex == '0) ? EXP_W'(1) : ex;
    u.m = {ex != '0, fr};
    return u;
  endfunction

  logic stall;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;

  assign stall    = valid_out & ~ready_out;
  assign ready_in = ~stall;

  // stage 1: unpack, classify, order by magnitude
  unp_t ua, ub;
  logic swap;

  always_comb begin
    ua   = unpack(num1, 1'b0);
    ub   = unpack(num2, op);
    swap = {ub.e, ub.m} > {ua.e, ua.m};
    s1_d       = '0;
    s1_d.vld   = valid_in;
    s1_d.nan   = ua.nan | ub.nan |
                 (ua.inf & ub.inf & (ua.s ^ ub.s));
    s1_d.inf   = ua.inf | ub.inf;
    s1_d.inf_s = ua.inf ? ua.s : ub.s;
    s1_d.sa    = swap ? ub.s : ua.s;
    s1_d.sb    = swap ? ua.s : ub.s;
    s1_d.ea    = swap ? ub.e : ua.e;
    s1_d.eb    = swap ? ua.e : ub.e;
    s1_d.ma    = swap ? ub.m : ua.m;
    s1_d.mb    = swap ? ua.m : ub.m;
  end

  // stage 2: align B with guard/round/sticky
  int            diff;
  logic [AW-1:0] sh;
  logic [TW-1:0] wide;

  always_comb begin
    diff = int'(s1_q.ea) - int'(s1_q.eb);
    sh   = (diff >= MAN_W + 3) ?
           AW'(MAN_W + 3) : AW'(diff);
    wide = {s1_q.mb, {(GW-1){1'b0}}} >> sh;
    s2_d       = '0;
    s2_d.vld   = s1_q.vld;
    s2_d.sa    = s1_q.sa;
    s2_d.sub   = s1_q.sa ^ s1_q.sb;
    s2_d.zs    = s1_q.sa & s1_q.sb;
    s2_d.ea    = s1_q.ea;
    s2_d.a     = {s1_q.ma, 3'b000};
    s2_d.b     = {wide[TW-1 -: GW-1], |wide[MW-1:0]};
    s2_d.nan   = s1_q.nan;
    s2_d.inf   = s1_q.inf;
    s2_d.inf_s = s1_q.inf_s;
  end

  // stage 3: magnitude add/sub and leading-zero count
  logic [SW-1:0] sum;
  logic [LW-1:0] lz;

  always_comb begin
    sum = s2_q.sub ?
          ({1'b0, s2_q.a} - {1'b0, s2_q.b}) :
          ({1'b0, s2_q.a} + {1'b0, s2_q.b});
    lz = LW'(GW);
    for (int i = 0; i < GW; i++)
      if (sum[i]) lz = LW'(GW - 1 - i);
    s3_d       = '0;
    s3_d.vld   = s2_q.vld;
    s3_d.sa    = s2_q.sa;
    s3_d.zs    = s2_q.zs;
    s3_d.ea    = s2_q.ea;
    s3_d.sum   = sum;
    s3_d.lz    = lz;
    s3_d.nan   = s2_q.nan;
    s3_d.inf   = s2_q.inf;
    s3_d.inf_s = s2_q.inf_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (!stall) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // stage 4: normalise, round, pack, flag
  int            lim, lz_i, ls_i, e_i;
  logic [GW-1:0] n;
  logic [MW:0]   mr;
  logic          g, r, s, inc, flush, fin, sum_z;
  logic          sel_nan, sel_inf, sel_zero;
  logic          sel_fl, sel_ov;
  logic [W-1:0]  res_d;
  logic          ovf_d, nan_d, pl_d, zero_d;

  always_comb begin
    lim   = int'(s3_q.ea) - 1;
    lz_i  = int'(s3_q.lz);
    ls_i  = 0;
    flush = 1'b0;
    if (s3_q.sum[SW-1]) begin
      n   = {s3_q.sum[SW-1:2], s3_q.sum[1] | s3_q.sum[0]};
      e_i = int'(s3_q.ea) + 1;
    end else begin
`ifdef FLOAT_ADDSUB_FTZ_EN
      ls_i  = lz_i;
      flush = lz_i > lim;
`else
      ls_i  = (lz_i > lim) ? lim : lz_i;
`endif
      n   = s3_q.sum[GW-1:0] << ls_i;
      e_i = int'(s3_q.ea) - ls_i;
    end
    g   = n[2];
    r   = n[1];
    s   = n[0];
    inc = g & (r | s | n[3]);
    mr  = {1'b0, n[GW-1:3]} + (MW+1)'(inc);
    if (mr[MW]) begin
      mr  = mr >> 1;
      e_i = e_i + 1;
    end

    sum_z    = s3_q.sum == '0;
    fin      = ~s3_q.nan & ~s3_q.inf;
    sel_nan  = s3_q.nan;
    sel_inf  = s3_q.inf & ~s3_q.nan;
    sel_zero = fin & sum_z;
    sel_fl   = fin & ~sum_z & flush;
    sel_ov   = fin & ~sum_z & ~flush & (e_i >= EMAX_I);

    res_d = '0;
    ovf_d = 1'b0;
    nan_d = 1'b0;
    pl_d  = 1'b0;
    unique case (1'b1)
      sel_nan: begin
        res_d = QNAN;
        nan_d = 1'b1;
      end
      sel_inf:  res_d = {s3_q.inf_s, EMAX, MZ};
      sel_zero: res_d = {s3_q.zs, {(W-1){1'b0}}};
      sel_fl: begin
        res_d = {s3_q.sa, {(W-1){1'b0}}};
        pl_d  = 1'b1;
      end
      sel_ov: begin
        res_d = {s3_q.sa, EMAX, MZ};
        ovf_d = 1'b1;
        pl_d  = 1'b1;
      end
      default: begin
        res_d = {s3_q.sa,
                 mr[MW-1] ? e_i[EXP_W-1:0] : {EXP_W{1'b0}},
                 mr[MAN_W-1:0]};
        pl_d  = g | r | s;
      end
    endcase
    zero_d = res_d[W-2:0] == '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out     <= 1'b0;
      result        <= '0;
      overflow      <= 1'b0;
      zero          <= 1'b0;
      NaN           <= 1'b0;
      precisionLost <= 1'b0;
    end else if (!stall) begin
      valid_out <= s3_q.vld;
      if (s3_q.vld) begin
        result        <= res_d;
        overflow      <= ovf_d;
        zero          <= zero_d;
        NaN           <= nan_d;
        precisionLost <= pl_d;
      end
    end
  end

endmodule

// File: tb/tb_float_addsub_pipelined_param.sv
// Bench for float_addsub_pipelined_param: exact-integer reference model,
// directed pins, random beats with random backpressure, stall and reset.
module tb_float_addsub_pipelined_param;

  localparam int EW   = 5;
  localparam int MW   = 10;
  localparam int W    = 1 + EW + MW;
  localparam int EMAX = (1 << EW) - 1;

  logic         clk = 0;
  logic         rst = 1;
  logic         valid_in = 0;
  logic         op = 0;
  logic         ready_out = 1;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic         ready_in, valid_out;
  logic         overflow, zero, NaN, precisionLost;
  logic [W-1:0] result;

  float_addsub_pipelined_param #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in),
    .op(op), .num1(num1), .num2(num2),
    .valid_out(valid_out), .ready_out(ready_out),
    .result(result), .overflow(overflow), .zero(zero),
    .NaN(NaN), .precisionLost(precisionLost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ov;
    logic         z;
    logic         nan;
    logic         pl;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   out_cnt = 0;
  bit   rnd_done = 0;
  exp_t q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Values are exact integers in units of the smallest subnormal.
  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic o);
    exp_t   e;
    logic   sa, sb, neg;
    int     ea, eb, p, sh, ex;
    longint fa, fb, va, vb, sm, mag, qq, rem, half;
    e  = '0;
    sa = a[W-1];
    sb = b[W-1] ^ o;
    ea = int'(a[W-2:MW]);
    eb = int'(b[W-2:MW]);
    fa = longint'(a[MW-1:0]);
    fb = longint'(b[MW-1:0]);
    if ((ea == EMAX && fa != 0) || (eb == EMAX && fb != 0) ||
        (ea == EMAX && eb == EMAX && sa != sb)) begin
      e.res = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      e.nan = 1;
      return e;
    end
    if (ea == EMAX) begin
      e.res = {sa, {EW{1'b1}}, {MW{1'b0}}};
      return e;
    end
    if (eb == EMAX) begin
      e.res = {sb, {EW{1'b1}}, {MW{1'b0}}};
      return e;
    end
`ifdef FLOAT_ADDSUB_FTZ_EN
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
`endif
    va = (ea == 0) ? fa : ((fa + (longint'(1) << MW)) << (ea - 1));
    vb = (eb == 0) ? fb : ((fb + (longint'(1) << MW)) << (eb - 1));
    if (sa) va = -va;
    if (sb) vb = -vb;
    sm = va + vb;
    if (sm == 0) begin
      e.res = {sa & sb, {(W-1){1'b0}}};
      e.z   = 1;
      return e;
    end
    neg = sm < 0;
    mag = neg ? -sm : sm;
    if (mag < (longint'(1) << MW)) begin
`ifdef FLOAT_ADDSUB_FTZ_EN
      e.res = {neg, {(W-1){1'b0}}};
      e.z   = 1;
      e.pl  = 1;
`else
      e.res = {neg, {EW{1'b0}}, mag[MW-1:0]};
`endif
      return e;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    sh   = p - MW;
    qq   = mag >> sh;
    rem  = mag - (qq << sh);
    half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    e.pl = rem != 0;
    if (rem > half || (sh > 0 && rem == half && qq[0])) qq++;
    ex = sh + 1;
    if (qq == (longint'(1) << (MW + 1))) begin
      qq = qq >> 1;
      ex++;
    end
    if (ex >= EMAX) begin
      e.res = {neg, {EW{1'b1}}, {MW{1'b0}}};
      e.ov  = 1;
      e.pl  = 1;
    end else begin
      e.res = {neg, ex[EW-1:0], qq[MW-1:0]};
    end
    return e;
  endfunction

  function automatic logic [W-1:0] gen();
    logic [W-1:0] x;
    x = W'($urandom);
    case ($urandom_range(0, 9))
      0: begin
        x[W-2:MW] = '1;
        if ($urandom_range(0, 1) == 1) x[MW-1:0] = '0;
      end
      1: x[W-2:MW] = '0;
      2: x[W-2:MW] = EW'(EMAX - 1 - $urandom_range(0, 1));
      3: x[MW-1:0] = '0;
      default: ;
    endcase
    return x;
  endfunction

  always @(posedge clk) cyc++;

  logic         held_v = 0;
  logic [W+3:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      held_v = 0;
    end else begin
      chk("ready_in", ready_in, !(valid_out && !ready_out));
      if (!ready_in) stall_cnt++;
      if (held_v)
        chk("held", {result, overflow, zero, NaN, precisionLost}, held);
      if (valid_in && ready_in) q.push_back(model(num1, num2, op));
      if (valid_out && ready_out) begin
        out_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", result);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("flags", {overflow, zero, NaN, precisionLost},
              {e.ov, e.z, e.nan, e.pl});
        end
      end
      held_v = valid_out && !ready_out;
      held   = {result, overflow, zero, NaN, precisionLost};
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic o, output int acc);
    int k;
    num1 = a;
    num2 = b;
    op = o;
    valid_in = 1;
    acc = -1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready_in) break;
    end
    if (k == 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=stalled required=accept");
    end else acc = cyc;
    @(posedge clk);
    #1;
    valid_in = 0;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic o, input logic [W-1:0] r,
                          input logic [3:0] f, output int acc);
    exp_t e;
    e = model(a, b, o);
    chk("model_res", e.res, r);
    chk("model_flags", {e.ov, e.z, e.nan, e.pl}, f);
    send(a, b, o, acc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] a, b;
    int acc, k;
    rst = 1;
    idle(3);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {overflow, zero, NaN, precisionLost}, 0);
    chk("rst_ready_in", ready_in, 1);
    rst = 0;
    idle(1);

    directed(16'h3C00, 16'h3C00, 0, 16'h4000, 4'b0000, acc);
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (valid_out) break;
    end
    chk("latency", cyc - acc, 4);
    chk("t1_result", result, 16'h4000);
    chk("t1_flags", {overflow, zero, NaN, precisionLost}, 0);
    idle(6);

    directed(16'hC0B0, 16'h1CC0, 0, 16'hC0AE, 4'b0001, acc);
    directed(16'hC0B0, 16'h1CC0, 1, 16'hC0B2, 4'b0001, acc);
    directed(16'h7BFF, 16'h7BFF, 0, 16'h7C00, 4'b1001, acc);
    directed(16'h7C00, 16'h7C00, 1, 16'h7E00, 4'b0010, acc);
    directed(16'h3C00, 16'h3C00, 1, 16'h0000, 4'b0100, acc);
    directed(16'h8000, 16'h8000, 0, 16'h8000, 4'b0100, acc);
    directed(16'h7C00, 16'hBC00, 0, 16'h7C00, 4'b0000, acc);
`ifdef FLOAT_ADDSUB_FTZ_EN
    directed(16'h0001, 16'h0001, 0, 16'h0000, 4'b0100, acc);
`else
    directed(16'h0001, 16'h0001, 0, 16'h0002, 4'b0000, acc);
`endif
    idle(8);
    chk("directed_drain", q.size(), 0);

    stall_cnt = 0;
    out_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(gen(), gen(), 1'($urandom_range(0, 1)), acc);
      end
      begin
        for (int j = 0; j < 20 && !valid_out; j++) begin
          @(posedge clk);
          #1;
        end
        ready_out = 0;
        repeat (3) @(posedge clk);
        #1;
        ready_out = 1;
      end
    join
    idle(10);
    chk("stall_cycles", stall_cnt, 3);
    chk("stall_out_cnt", out_cnt, 6);
    chk("stall_drain", q.size(), 0);

    for (int i = 0; i < 3; i++)
      send(gen(), gen(), 1'($urandom_range(0, 1)), acc);
    rst = 1;
    @(negedge clk);
    chk("midrst_valid_out", valid_out, 0);
    @(posedge clk);
    #1;
    rst = 0;
    out_cnt = 0;
    idle(10);
    chk("midrst_no_stale", out_cnt, 0);

    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 4) != 0) begin
            a = gen();
            b = ($urandom_range(0, 3) == 0) ?
                (a ^ W'($urandom_range(0, 7)) ^
                 {1'($urandom_range(0, 1)), {(W-1){1'b0}}}) :
                gen();
            send(a, b, 1'($urandom_range(0, 1)), acc);
          end else idle(1);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_out = 1;
    idle(12);
    chk("random_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
